// File: rtl/poly_mult_host_ctrl.sv
// Host-side controller for the polynomial multiplier core.
// Owns the sparse position RAM and the dense vector RAM, decodes host
// commands, sequences core runs and returns read responses two cycles
// after a read command is accepted.
module poly_mult_host_ctrl #(
    parameter int MAX_WEIGHT = 75,
    parameter int POS_W      = 16,
    parameter int WORD_W     = 32,
    parameter int DEPTH      = 553,
    parameter int BUS_W      = 128,
    parameter int ADDR_W     = 10,
    parameter int DUMMY_POS  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [BUS_W-1:0]              cmd_data,
    output logic                          rsp_valid,
    output logic [BUS_W-1:0]              rsp_data,
    output logic                          busy,
    output logic                          err,
    output logic                          core_start,
    input  logic [$clog2(MAX_WEIGHT)-1:0] core_loc_addr,
    output logic [POS_W-1:0]              core_loc_in,
    output logic                          core_loc_dummy,
    input  logic [ADDR_W-1:0]             core_addr_0,
    input  logic [ADDR_W-1:0]             core_addr_1,
    output logic [WORD_W-1:0]             core_word_0,
    output logic [WORD_W-1:0]             core_word_1,
    input  logic                          core_valid,
    output logic [ADDR_W-1:0]             core_res_addr,
    output logic                          core_rd,
    input  logic [WORD_W-1:0]             core_res_dout
);

    localparam int LOC_W  = $clog2(MAX_WEIGHT);
    localparam int WT_W   = $clog2(MAX_WEIGHT + 1);
    localparam int VEC_AW = $clog2(DEPTH);

    localparam logic [31:0]      MAX_WEIGHT_U   = MAX_WEIGHT;
    localparam logic [31:0]      DEPTH_U        = DEPTH;
    localparam logic [BUS_W-1:0] MAX_WEIGHT_BUS = BUS_W'(MAX_WEIGHT);
    localparam logic [POS_W-1:0] DUMMY_VAL      = POS_W'(DUMMY_POS);

    typedef enum logic [2:0] {
        OP_WR_POS     = 3'd0,
        OP_RD_POS     = 3'd1,
        OP_WR_VEC     = 3'd2,
        OP_RD_VEC     = 3'd3,
        OP_SET_WEIGHT = 3'd4,
        OP_START      = 3'd5,
        OP_RD_RES     = 3'd6,
        OP_ABORT      = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RESP    = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, next_state, ret_state;
    op_t    op;

    logic              accept;
    logic              pos_oor;
    logic              vec_oor;
    logic              wt_ok;
    logic              loc_dummy;
    logic              rd_from_core;
    logic [WT_W-1:0]   weight;
    logic [BUS_W-1:0]  rd_buf;

    logic [POS_W-1:0]  pos_mem [MAX_WEIGHT];
    logic [WORD_W-1:0] vec_mem [DEPTH];

    assign op        = op_t'(cmd_op);
    assign pos_oor   = 32'(cmd_addr) >= MAX_WEIGHT_U;
    assign vec_oor   = 32'(cmd_addr) >= DEPTH_U;
    assign wt_ok     = (cmd_data != '0) && (cmd_data <= MAX_WEIGHT_BUS);
    assign loc_dummy = 32'(core_loc_addr) >= 32'(weight);

    // While a core run is active only ABORT may enter; reset holds the host off.
    assign cmd_ready = !rst && ((state == IDLE) || (state == DONE) ||
                                ((state == RUN) && (op == OP_ABORT)));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == RUN);

    // The result RAM in the core has one cycle of latency, so its read is
    // issued on the acceptance cycle to land in RD_WAIT with the local RAMs.
    assign core_rd       = accept && (op == OP_RD_RES) && (state == DONE);
    assign core_res_addr = core_rd ? cmd_addr : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values;
        // blocking = here would make results depend on statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so every path drives next_state and no
        // latch is inferred for branches that do not mention it.
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (op == OP_RD_POS || op == OP_RD_VEC || op == OP_RD_RES) begin
                        next_state = RD_WAIT;
                    end else if (op == OP_START) begin
                        next_state = RUN;
                    end
                end
            end
            RD_WAIT: next_state = RESP;
            RESP:    next_state = ret_state;
            RUN: begin
                if (accept) begin
                    next_state = IDLE;
                end else if (core_valid) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command side effects: weight, sticky error, start pulse and read responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight       <= WT_W'(MAX_WEIGHT);
            err          <= 1'b0;
            core_start   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rd_buf       <= '0;
            rd_from_core <= 1'b0;
            ret_state    <= IDLE;
        end else begin
            core_start <= accept && (op == OP_START);
            rsp_valid  <= (state == RD_WAIT);
            if (state == RD_WAIT) begin
                rsp_data <= rd_from_core ? BUS_W'(core_res_dout) : rd_buf;
            end
            if (accept) begin
                unique case (op)
                    OP_WR_POS: if (pos_oor) err <= 1'b1;
                    OP_WR_VEC: if (vec_oor) err <= 1'b1;
                    OP_RD_POS: begin
                        ret_state    <= state;
                        rd_from_core <= 1'b0;
                        if (pos_oor) begin
                            err    <= 1'b1;
                            rd_buf <= '0;
                        end else begin
                            rd_buf <= BUS_W'(pos_mem[cmd_addr[LOC_W-1:0]]);
                        end
                    end
                    OP_RD_VEC: begin
                        ret_state    <= state;
                        rd_from_core <= 1'b0;
                        if (vec_oor) begin
                            err    <= 1'b1;
                            rd_buf <= '0;
                        end else begin
                            rd_buf <= BUS_W'(vec_mem[cmd_addr[VEC_AW-1:0]]);
                        end
                    end
                    OP_RD_RES: begin
                        // No result exists until a run has completed.
                        ret_state    <= state;
                        rd_buf       <= '0;
                        rd_from_core <= (state == DONE);
                        if (state != DONE) err <= 1'b1;
                    end
                    OP_SET_WEIGHT: begin
                        if (wt_ok) weight <= cmd_data[WT_W-1:0];
                        else       err    <= 1'b1;
                    end
                    OP_START: err <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // RAM writes from the host and synchronous reads for the core.
    always_ff @(posedge clk) begin
        // NOTE: RAM arrays and their read registers have no reset; clearing
        // them would prevent block-RAM mapping and contents survive rst.
        if (accept && (op == OP_WR_POS) && !pos_oor) begin
            pos_mem[cmd_addr[LOC_W-1:0]] <= cmd_data[POS_W-1:0];
        end
        if (accept && (op == OP_WR_VEC) && !vec_oor) begin
            vec_mem[cmd_addr[VEC_AW-1:0]] <= cmd_data[WORD_W-1:0];
        end
        core_loc_dummy <= loc_dummy;
        core_loc_in    <= loc_dummy ? DUMMY_VAL : pos_mem[core_loc_addr];
        core_word_0    <= (32'(core_addr_0) < DEPTH_U) ? vec_mem[core_addr_0[VEC_AW-1:0]] : '0;
        core_word_1    <= (32'(core_addr_1) < DEPTH_U) ? vec_mem[core_addr_1[VEC_AW-1:0]] : '0;
    end

endmodule

// File: tb/tb_poly_mult_host_ctrl.sv
// Self-checking bench for poly_mult_host_ctrl: directed scenarios followed by
// randomized host commands, all checked against a behavioural model that keeps
// RAM images, the runtime weight, the error flag and the run phase.
module tb_poly_mult_host_ctrl;

    localparam int MW        = 75;
    localparam int POS_W     = 16;
    localparam int WORD_W    = 32;
    localparam int DEPTH     = 553;
    localparam int BUS_W     = 128;
    localparam int ADDR_W    = 10;
    localparam int DUMMY_POS = 0;
    localparam int LOC_W     = 7;

    localparam logic [2:0] OP_WR_POS     = 3'd0;
    localparam logic [2:0] OP_RD_POS     = 3'd1;
    localparam logic [2:0] OP_WR_VEC     = 3'd2;
    localparam logic [2:0] OP_RD_VEC     = 3'd3;
    localparam logic [2:0] OP_SET_WEIGHT = 3'd4;
    localparam logic [2:0] OP_START      = 3'd5;
    localparam logic [2:0] OP_RD_RES     = 3'd6;
    localparam logic [2:0] OP_ABORT      = 3'd7;

    typedef enum {PH_IDLE, PH_RUN, PH_DONE} phase_t;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BUS_W-1:0]  cmd_data;
    logic              rsp_valid;
    logic [BUS_W-1:0]  rsp_data;
    logic              busy;
    logic              err;
    logic              core_start;
    logic [LOC_W-1:0]  core_loc_addr;
    logic [POS_W-1:0]  core_loc_in;
    logic              core_loc_dummy;
    logic [ADDR_W-1:0] core_addr_0;
    logic [ADDR_W-1:0] core_addr_1;
    logic [WORD_W-1:0] core_word_0;
    logic [WORD_W-1:0] core_word_1;
    logic              core_valid;
    logic [ADDR_W-1:0] core_res_addr;
    logic              core_rd;
    logic [WORD_W-1:0] core_res_dout;

    poly_mult_host_ctrl #(
        .MAX_WEIGHT(MW), .POS_W(POS_W), .WORD_W(WORD_W), .DEPTH(DEPTH),
        .BUS_W(BUS_W), .ADDR_W(ADDR_W), .DUMMY_POS(DUMMY_POS)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err(err), .core_start(core_start),
        .core_loc_addr(core_loc_addr), .core_loc_in(core_loc_in),
        .core_loc_dummy(core_loc_dummy),
        .core_addr_0(core_addr_0), .core_addr_1(core_addr_1),
        .core_word_0(core_word_0), .core_word_1(core_word_1),
        .core_valid(core_valid), .core_res_addr(core_res_addr),
        .core_rd(core_rd), .core_res_dout(core_res_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [POS_W-1:0]  pos_m [MW];
    logic [WORD_W-1:0] vec_m [DEPTH];
    int                weight_m;
    logic              err_m;
    phase_t            phase;

    task automatic check(input string tag, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Result word the modelled core holds at each address.
    function automatic logic [WORD_W-1:0] res_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [BUS_W-1:0] rand_bus();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One host command, issued at a falling edge and held for one cycle.
    task automatic do_cmd(input logic [2:0] op, input int addr, input logic [BUS_W-1:0] data);
        logic             exp_ready, exp_rd, exp_start, is_read;
        logic [BUS_W-1:0] exp_rsp;
        exp_ready = (phase != PH_RUN) || (op == OP_ABORT);
        exp_rd    = 1'b0;
        is_read   = 1'b0;
        exp_rsp   = '0;
        exp_start = exp_ready && (op == OP_START);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = ADDR_W'(addr);
        cmd_data  = data;
        #1;
        check("cmd_ready", cmd_ready, exp_ready);
        if (exp_ready) begin
            case (op)
                OP_WR_POS: if (addr < MW) pos_m[addr] = data[POS_W-1:0]; else err_m = 1'b1;
                OP_WR_VEC: if (addr < DEPTH) vec_m[addr] = data[WORD_W-1:0]; else err_m = 1'b1;
                OP_RD_POS: begin
                    is_read = 1'b1;
                    if (addr < MW) exp_rsp = BUS_W'(pos_m[addr]); else err_m = 1'b1;
                end
                OP_RD_VEC: begin
                    is_read = 1'b1;
                    if (addr < DEPTH) exp_rsp = BUS_W'(vec_m[addr]); else err_m = 1'b1;
                end
                OP_RD_RES: begin
                    is_read = 1'b1;
                    if (phase == PH_DONE) begin
                        exp_rd  = 1'b1;
                        exp_rsp = BUS_W'(res_word(addr));
                    end else begin
                        err_m = 1'b1;
                    end
                end
                OP_SET_WEIGHT: begin
                    if (data >= 1 && data <= MW) weight_m = int'(data[7:0]);
                    else err_m = 1'b1;
                end
                OP_START: begin
                    err_m = 1'b0;
                    phase = PH_RUN;
                end
                default: if (phase == PH_RUN) phase = PH_IDLE;
            endcase
        end
        check("core_rd", core_rd, exp_rd);
        if (exp_rd) check("core_res_addr", core_res_addr, addr);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_data  = rand_bus();
        if (exp_rd) core_res_dout = res_word(addr);
        @(negedge clk);
        check("err", err, err_m);
        check("busy", busy, phase == PH_RUN);
        check("core_start", core_start, exp_start);
        check("rsp_valid_early", rsp_valid, 1'b0);
        if (is_read) begin
            @(posedge clk);
            #1;
            core_res_dout = $urandom;
            @(negedge clk);
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_data", rsp_data, exp_rsp);
            @(negedge clk);
            check("rsp_valid_after", rsp_valid, 1'b0);
        end else begin
            @(negedge clk);
            check("rsp_valid_none", rsp_valid, 1'b0);
            check("core_start_pulse", core_start, 1'b0);
        end
    endtask

    task automatic probe_loc(input int idx);
        logic [POS_W-1:0] exp_pos;
        logic             exp_dummy;
        core_loc_addr = LOC_W'(idx);
        exp_dummy     = (idx >= weight_m);
        exp_pos       = exp_dummy ? POS_W'(DUMMY_POS) : pos_m[idx];
        @(negedge clk);
        check("core_loc_dummy", core_loc_dummy, exp_dummy);
        check("core_loc_in", core_loc_in, exp_pos);
    endtask

    task automatic probe_words(input int a0, input int a1);
        logic [WORD_W-1:0] e0, e1;
        core_addr_0 = ADDR_W'(a0);
        core_addr_1 = ADDR_W'(a1);
        e0 = (a0 < DEPTH) ? vec_m[a0] : '0;
        e1 = (a1 < DEPTH) ? vec_m[a1] : '0;
        @(negedge clk);
        check("core_word_0", core_word_0, e0);
        check("core_word_1", core_word_1, e1);
    endtask

    task automatic core_finish();
        core_valid = 1'b1;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        if (phase == PH_RUN) phase = PH_DONE;
        @(negedge clk);
        check("busy_after_valid", busy, phase == PH_RUN);
    endtask

    function automatic int pick_addr(input int limit);
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(limit, 1023));
        return int'($urandom_range(0, limit - 1));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = '0;
        cmd_addr      = '0;
        cmd_data      = '0;
        core_loc_addr = '0;
        core_addr_0   = '0;
        core_addr_1   = '0;
        core_valid    = 1'b0;
        core_res_dout = $urandom;
        weight_m      = MW;
        err_m         = 1'b0;
        phase         = PH_IDLE;

        // Outputs held at zero while reset is asserted.
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_core_rd", core_rd, 1'b0);
        check("rst_core_res_addr", core_res_addr, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fill both RAMs so every later read has a known value.
        for (int i = 0; i < MW; i++) do_cmd(OP_WR_POS, i, rand_bus());
        for (int i = 0; i < DEPTH; i++) do_cmd(OP_WR_VEC, i, rand_bus());

        // Position write/read round trip and reset weight boundary.
        do_cmd(OP_WR_POS, 3, 128'h1A2B);
        do_cmd(OP_RD_POS, 3, '0);
        probe_loc(74);
        probe_loc(75);

        // Dummy insertion at weight 66.
        do_cmd(OP_SET_WEIGHT, 0, 128'd66);
        probe_loc(66);
        probe_loc(65);

        // Vector port range handling.
        do_cmd(OP_WR_VEC, 0, 128'hDEAD_BEEF);
        probe_words(553, 0);
        probe_words(552, 1023);

        // Errors: out-of-range read, bad weights; START clears the flag.
        do_cmd(OP_RD_VEC, 553, '0);
        do_cmd(OP_SET_WEIGHT, 0, 128'd76);
        do_cmd(OP_SET_WEIGHT, 0, 128'd0);
        probe_loc(66);
        probe_loc(65);
        do_cmd(OP_WR_POS, 75, 128'h7777);
        do_cmd(OP_START, 0, '0);

        // Run: host held off, completion, result read, restart from DONE.
        do_cmd(OP_WR_VEC, 5, 128'h1234);
        do_cmd(OP_RD_POS, 3, '0);
        core_finish();
        do_cmd(OP_RD_RES, 5, '0);
        do_cmd(OP_RD_POS, 3, '0);
        do_cmd(OP_RD_RES, 9, '0);
        do_cmd(OP_ABORT, 0, '0);
        do_cmd(OP_START, 0, '0);
        core_finish();

        // Abort mid-run, then result read before any completion from IDLE.
        do_cmd(OP_START, 0, '0);
        do_cmd(OP_ABORT, 0, '0);
        do_cmd(OP_RD_RES, 5, '0);
        do_cmd(OP_ABORT, 0, '0);

        // Asynchronous reset during a run.
        do_cmd(OP_START, 0, '0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        phase    = PH_IDLE;
        weight_m = MW;
        err_m    = 1'b0;
        @(negedge clk);
        check("post_rst_err", err, 1'b0);
        probe_loc(74);
        do_cmd(OP_RD_POS, 3, '0);

        // Randomized command traffic.
        for (int it = 0; it < 400; it++) begin
            logic [2:0]       op;
            int               addr;
            logic [BUS_W-1:0] data;
            if (phase == PH_RUN && $urandom_range(0, 2) == 0) begin
                core_finish();
            end else begin
                op   = 3'($urandom_range(0, 7));
                addr = (op == OP_WR_VEC || op == OP_RD_VEC) ? pick_addr(DEPTH) : pick_addr(MW);
                data = rand_bus();
                if (op == OP_SET_WEIGHT && $urandom_range(0, 3) != 0) data = BUS_W'($urandom_range(0, 80));
                do_cmd(op, addr, data);
            end
            if ($urandom_range(0, 1) == 0) probe_loc(int'($urandom_range(0, 127)));
            else probe_words(int'($urandom_range(0, 1023)), pick_addr(DEPTH));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
